// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store unit front end: aligns stores onto a 32-bit
// word port and extracts/extends load data, flagging misaligned accesses.
module lsu_mem_ctrl #(
  parameter bit STORE_RESP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [1:0]  in_size,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_misalign,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

  state_t      r_state, w_next;
  logic        r_wen, r_signed, r_misalign;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [1:0]  r_size;

  logic        w_mis;
  logic [31:0] w_shift, w_ld, w_wd_trunc, w_st_data;
  logic [3:0]  w_mask4;

  assign w_mis = (in_size == 2'd3) ||
                 (in_size == 2'd1 && in_addr[0]) ||
                 (in_size == 2'd2 && in_addr[1:0] != 2'b00);

  // Load path: move the addressed lane down to bit 0, then extend.
  assign w_shift = mem_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_ld       = w_shift;
    w_wd_trunc = r_wdata;
    w_mask4    = 4'b1111;
    case (r_size)
      2'd0: begin
        w_ld       = {{24{r_signed & w_shift[7]}}, w_shift[7:0]};
        w_wd_trunc = {24'd0, r_wdata[7:0]};
        w_mask4    = 4'b0001 << r_addr[1:0];
      end
      2'd1: begin
        w_ld       = {{16{r_signed & w_shift[15]}}, w_shift[15:0]};
        w_wd_trunc = {16'd0, r_wdata[15:0]};
        w_mask4    = 4'b0011 << r_addr[1:0];
      end
      default: ;
    endcase
  end

  assign w_st_data = w_wd_trunc << {r_addr[1:0], 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (in_valid) w_next = w_mis ? S_RESP : S_ISSUE;
      S_ISSUE:   w_next = S_CAPTURE;
      S_CAPTURE: w_next = (r_wen && !STORE_RESP) ? S_IDLE : S_RESP;
      S_RESP:    if (out_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_size     <= '0;
      r_signed   <= 1'b0;
      r_rdata    <= '0;
      r_misalign <= 1'b0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_wen      <= in_wen;
      r_addr     <= in_addr;
      r_wdata    <= in_wdata;
      r_size     <= in_size;
      r_signed   <= in_signed;
      r_rdata    <= '0;
      r_misalign <= w_mis;
    end else if (r_state == S_CAPTURE) begin
      r_rdata    <= r_wen ? 32'd0 : w_ld;
    end
  end

  // Memory outputs decode straight from state so reset kills them immediately.
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_RESP);
    mem_valid = 1'b0;
    mem_wen   = 1'b0;
    mem_raddr = '0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (r_state == S_ISSUE) begin
      mem_valid = 1'b1;
      mem_wen   = r_wen;
      mem_raddr = {r_addr[31:2], 2'b00};
      mem_waddr = {r_addr[31:2], 2'b00};
      if (r_wen) begin
        mem_wdata = w_st_data;
        mem_wmask = {4'b0000, w_mask4};
      end
    end
  end

  assign out_rdata    = r_rdata;
  assign out_misalign = r_misalign;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: byte-level memory model, random and
// directed requests, decoupled memory-port and response monitors.
module tb_lsu_mem_ctrl;

  typedef struct packed { logic [31:0] rdata; logic mis; } resp_t;
  typedef struct packed { logic wen; logic [31:0] addr; logic [7:0] mask; logic [31:0] wdata; } memtx_t;

  logic        clk, rst_n;
  logic        in_valid, in_ready, in_wen, in_signed;
  logic [31:0] in_addr, in_wdata;
  logic [1:0]  in_size;
  logic        out_valid, out_ready, out_misalign;
  logic [31:0] out_rdata;
  logic        mem_valid, mem_wen;
  logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  int tests, fails, cyc;
  resp_t  resp_q[$];
  memtx_t mem_q[$];
  int     acc_q[$], elat_q[$];
  logic [7:0]  mbytes[int unsigned];
  logic [31:0] rmem[int unsigned];
  logic force_rdy, force_val;

  lsu_mem_ctrl #(.STORE_RESP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_size(in_size), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_misalign(out_misalign),
    .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_raddr(mem_raddr),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    cyc = 0;
    forever begin @(posedge clk); cyc++; end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: got timeout expected event (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [31:0] init_word(input int unsigned wa);
    return (wa * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [7:0] mb(input int unsigned a);
    logic [31:0] w;
    if (mbytes.exists(a)) return mbytes[a];
    w = init_word(a >> 2);
    return w[8*(a%4) +: 8];
  endfunction

  task automatic preload(input logic [31:0] addr, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mbytes[{addr[31:2], 2'b00} + i] = w[8*i +: 8];
    rmem[addr >> 2] = w;
  endtask

  // Caller must be at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] sz, input logic sgn,
                       input logic use_exp, input logic [31:0] exp_rd);
    int n;
    int unsigned nb, off;
    logic mis;
    logic [31:0] v, wm;
    memtx_t m;
    in_valid = 1'b1; in_wen = wen; in_addr = addr; in_wdata = wd;
    in_size = sz; in_signed = sgn;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      fail_now("accept_timeout");
      in_valid = 1'b0;
      return;
    end
    mis = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00);
    nb  = 1 << sz;
    off = addr % 4;
    acc_q.push_back(cyc + 1);
    if (mis) begin
      resp_q.push_back('{rdata: 32'd0, mis: 1'b1});
      elat_q.push_back(0);
    end else if (wen) begin
      wm = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
      m.wen = 1'b1; m.addr = addr & ~32'd3;
      m.mask = 8'(((1 << nb) - 1) << off);
      m.wdata = (wd & wm) << (8*off);
      mem_q.push_back(m);
      for (int i = 0; i < int'(nb); i++) mbytes[addr + i] = wd[8*i +: 8];
      resp_q.push_back('{rdata: 32'd0, mis: 1'b0});
      elat_q.push_back(2);
    end else begin
      m.wen = 1'b0; m.addr = addr & ~32'd3; m.mask = 8'd0; m.wdata = 32'd0;
      mem_q.push_back(m);
      v = 32'd0;
      for (int i = 0; i < int'(nb); i++) v = v | (32'(mb(addr + i)) << (8*i));
      if (sgn && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      resp_q.push_back('{rdata: use_exp ? exp_rd : v, mis: 1'b0});
      elat_q.push_back(2);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((resp_q.size() != 0 || !in_ready) && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) fail_now("drain_timeout");
  endtask

  // Memory environment: word store with byte masks, read data one cycle later.
  initial begin
    logic pend;
    logic [31:0] rw, cw;
    int unsigned wa;
    pend = 1'b0; rw = 32'd0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      mem_rdata = pend ? rw : $urandom;
      pend = 1'b0;
      if (rst_n && mem_valid) begin
        if (mem_wen) begin
          wa = mem_waddr >> 2;
          cw = rmem.exists(wa) ? rmem[wa] : init_word(wa);
          for (int i = 0; i < 4; i++) if (mem_wmask[i]) cw[8*i +: 8] = mem_wdata[8*i +: 8];
          rmem[wa] = cw;
        end else begin
          wa = mem_raddr >> 2;
          rw = rmem.exists(wa) ? rmem[wa] : init_word(wa);
          pend = 1'b1;
        end
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = force_rdy ? force_val : ($urandom_range(0, 9) < 7);
    end
  end

  // Memory-port monitor.
  initial begin
    memtx_t m;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (mem_valid) begin
        if (mem_q.size() == 0) begin
          chk("unexpected_mem_valid", 32'(mem_valid), 32'd0);
        end else begin
          m = mem_q.pop_front();
          chk("mem_wen", 32'(mem_wen), 32'(m.wen));
          chk("mem_raddr", mem_raddr, m.addr);
          chk("mem_waddr", mem_waddr, m.addr);
          chk("mem_wmask", 32'(mem_wmask), 32'(m.mask));
          if (m.wen) chk("mem_wdata", mem_wdata, m.wdata);
        end
      end else begin
        chk("mem_idle_zero", 32'(mem_wen) | 32'(mem_wmask) | mem_wdata | mem_raddr | mem_waddr, 32'd0);
      end
    end
  end

  // Response monitor: latency, stall stability, handshake, return to idle.
  initial begin
    logic pv, hs_prev, stall, sm;
    logic [31:0] sr;
    resp_t r;
    int a, e;
    pv = 1'b0; hs_prev = 1'b0; stall = 1'b0; sm = 1'b0; sr = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin pv = 1'b0; hs_prev = 1'b0; stall = 1'b0; continue; end
      if (hs_prev) chk("idle_after_hs", {30'd0, in_ready, out_valid}, 32'd2);
      hs_prev = 1'b0;
      if (out_valid) begin
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        if (!pv) begin
          if (acc_q.size() == 0) chk("unexpected_resp", 32'(out_valid), 32'd0);
          else begin
            a = acc_q.pop_front(); e = elat_q.pop_front();
            chk("resp_latency", 32'(cyc - a), 32'(e));
          end
        end
        if (stall) begin
          chk("stall_rdata", out_rdata, sr);
          chk("stall_mis", 32'(out_misalign), 32'(sm));
        end
        if (out_ready) begin
          if (resp_q.size() == 0) chk("unexpected_hs", 32'(out_valid), 32'd0);
          else begin
            r = resp_q.pop_front();
            chk("out_rdata", out_rdata, r.rdata);
            chk("out_misalign", 32'(out_misalign), 32'(r.mis));
          end
          hs_prev = 1'b1; stall = 1'b0;
        end else begin
          stall = 1'b1; sr = out_rdata; sm = out_misalign;
        end
      end else stall = 1'b0;
      pv = out_valid;
    end
  end

  initial begin
    int n;
    tests = 0; fails = 0;
    force_rdy = 1'b0; force_val = 1'b0;
    in_valid = 1'b0; in_wen = 1'b0; in_addr = 32'd0; in_wdata = 32'd0;
    in_size = 2'd0; in_signed = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_rdata", out_rdata, 32'd0);
    chk("rst_out_mis", 32'(out_misalign), 32'd0);
    chk("rst_mem", 32'(mem_valid) | 32'(mem_wen) | 32'(mem_wmask) | mem_wdata | mem_raddr | mem_waddr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    preload(32'h8000_0004, 32'hDEAD_BEEF);
    issue(1'b0, 32'h8000_0004, 32'd0, 2'd2, 1'b0, 1'b1, 32'hDEAD_BEEF);
    preload(32'h8000_0000, 32'h8511_2233);
    issue(1'b0, 32'h8000_0003, 32'd0, 2'd0, 1'b1, 1'b1, 32'hFFFF_FF85);
    issue(1'b0, 32'h8000_0003, 32'd0, 2'd0, 1'b0, 1'b1, 32'h0000_0085);
    issue(1'b1, 32'h8000_0002, 32'h1234_ABCD, 2'd1, 1'b0, 1'b0, 32'd0);
    issue(1'b0, 32'h8000_0006, 32'd0, 2'd2, 1'b0, 1'b0, 32'd0);
    wait_drain();

    // Back-pressure: hold out_ready low five cycles in RESP.
    force_rdy = 1'b1; force_val = 1'b0;
    issue(1'b0, 32'h8000_0010, 32'd0, 2'd1, 1'b1, 1'b0, 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    if (!out_valid) fail_now("resp_wait_timeout");
    repeat (5) @(negedge clk);
    chk("held_out_valid", 32'(out_valid), 32'd1);
    force_val = 1'b1;
    wait_drain();
    force_rdy = 1'b0;

    // Reset pulse while the memory access is being issued.
    issue(1'b0, 32'h8000_0020, 32'd0, 2'd2, 1'b0, 1'b0, 32'd0);
    #2;
    chk("abort_pre_mem_valid", 32'(mem_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_mem_valid", 32'(mem_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    resp_q.delete(); acc_q.delete(); elat_q.delete(); mem_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_abort_in_ready", 32'(in_ready), 32'd1);
    chk("post_abort_out_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 300; i++)
      issue(1'($urandom), 32'h8000_0000 + $urandom_range(0, 63), $urandom,
            2'($urandom), 1'($urandom), 1'b0, 32'd0);
    wait_drain();
    repeat (3) @(negedge clk);
    chk("mem_q_empty", 32'(mem_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 The block SHALL expose parameter STORE_RESP, default 1, meaning 1: stores return an out_valid completion, 0: stores complete silently.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (all state on posedge); rst_n input 1 (asynchronous, active-low).
REQ-003 The block SHALL expose: in_valid input 1, the upstream request is valid; in_ready output 1, the block can accept a request.
REQ-004 The block SHALL expose: in_wen input 1 (1 store, 0 load); in_addr input 32, byte address; in_wdata input 32, store data, right-aligned.
REQ-005 The block SHALL expose: in_size input 2 (0 byte, 1 half, 2 word, 3 illegal); in_signed input 1, sign-extend loads.
REQ-006 The block SHALL expose: out_valid output 1; out_ready input 1; out_rdata output 32, extended load data; out_misalign output 1, error flag for the response.
REQ-007 The block SHALL expose memory-side ports: mem_valid output 1; mem_wen output 1; mem_raddr output 32; mem_waddr output 32; mem_wdata output 32; mem_wmask output 8; mem_rdata input 32, valid in the cycle after the memory samples a read.

Function
REQ-008 The FSM SHALL have states IDLE, ISSUE, CAPTURE, RESP; in_ready=1 only in IDLE.
REQ-009 On posedge in IDLE with in_valid=1, the block SHALL latch wen/addr/wdata/size/signed and go to ISSUE, or go to RESP if the access is misaligned.
REQ-010 Misaligned SHALL mean size=3, size=1 with addr[0]=1, or size=2 with addr[1:0]!=0; such requests SHALL never assert mem_valid.
REQ-011 In ISSUE, mem_valid SHALL be 1 for exactly one cycle; in all other states mem_valid, mem_wen, mem_wdata and mem_wmask SHALL be 0.
REQ-012 mem_raddr and mem_waddr SHALL both be {addr[31:2],2'b00} in ISSUE, and 0 otherwise.
REQ-013 mem_wmask[3:0] SHALL be 4'b0001<<addr[1:0] for byte, 4'b0011<<addr[1:0] for half, and 4'b1111 for word; mem_wmask[7:4] SHALL be 0; for loads mem_wmask SHALL be 0.
REQ-014 mem_wdata SHALL be in_wdata shifted left by 8*addr[1:0], with bits above the access size zeroed before the shift.
REQ-015 ISSUE SHALL always go to CAPTURE.
REQ-016 In CAPTURE, for a load, the block SHALL register out_rdata = (mem_rdata>>8*addr[1:0]) truncated to the access size, then zero- or sign-extended per in_signed.
REQ-017 In CAPTURE, for a store, the block SHALL set out_rdata=0 and go to RESP if STORE_RESP=1, else to IDLE.
REQ-018 In RESP, out_valid SHALL be 1, and out_rdata/out_misalign SHALL be stable until the posedge where out_ready=1, after which the FSM SHALL return to IDLE.
REQ-019 For a misaligned response, out_rdata SHALL be 0 and out_misalign SHALL be 1; out_misalign SHALL otherwise be 0.
REQ-020 Load latency SHALL be: accept at edge N gives out_valid high after edge N+2; with out_ready held high, in_ready returns after edge N+3.
REQ-021 The block SHALL accept no new request while busy; out_ready asserted outside RESP SHALL be ignored.

Reset
REQ-022 While rst_n=0, the block SHALL immediately force: state IDLE, in_ready=1, out_valid=0, out_rdata=0, out_misalign=0, all mem_* outputs 0, latched request 0.
REQ-023 A reset asserted in ISSUE SHALL drop mem_valid in the same cycle, with no further memory access and no response for the aborted request.

Verification
REQ-024 The bench SHALL cover a word load at addr 0x80000004 with mem_rdata=0xDEADBEEF -> mem_raddr=0x80000004, mem_wmask=0, out_rdata=0xDEADBEEF after 3 edges.
REQ-025 The bench SHALL cover a signed byte load at addr 0x80000003 with mem_rdata=0x85112233 -> out_rdata=0xFFFFFF85; the unsigned variant -> 0x00000085.
REQ-026 The bench SHALL cover a half store at addr 0x80000002 with wdata=0x1234ABCD -> mem_wen=1, mem_waddr=0x80000000, mem_wmask=0x0C, mem_wdata=0xABCD0000.
REQ-027 The bench SHALL cover a word load at addr 0x80000006 -> mem_valid never 1, out_valid=1 with out_misalign=1 and out_rdata=0.
REQ-028 The bench SHALL cover out_ready held 0 for 5 cycles in RESP -> out_valid and out_rdata stable, in_ready=0, with IDLE reached on the edge after out_ready=1.
REQ-029 The bench SHALL cover rst_n pulsed low during ISSUE -> mem_valid=0 in the same cycle, in_ready=1 and out_valid=0 after release.
